// File: rtl/w4_weight_unpack.sv
// Splits a wide packed-int4 weight word into SPLIT_LEVEL beats (LSB slice first) and
// expands every nibble to an int8 lane, signed or offset by a zero point.
module w4_weight_unpack #(
   parameter int INPUT_DATA_WIDTH  = 1024,
   parameter int LANES             = 64,
   parameter int OUTPUT_DATA_WIDTH = LANES * 8,
   parameter int SPLIT_LEVEL       = INPUT_DATA_WIDTH / (4 * LANES)
) (
   input  logic                         clk,
   input  logic                         areset_n,
   input  logic                         ap_start,
   input  logic                         zp_en,
   input  logic [3:0]                   zp,
   input  logic [INPUT_DATA_WIDTH-1:0]  data_in,
   input  logic                         valid_in,
   input  logic                         last_in,
   output logic                         ready_out,
   output logic [OUTPUT_DATA_WIDTH-1:0] data_out,
   output logic                         valid_out,
   output logic                         last_out,
   input  logic                         ready_in
);

   localparam int BEAT_W = 4 * LANES;
   localparam int CNT_W  = (SPLIT_LEVEL > 1) ? $clog2(SPLIT_LEVEL) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(SPLIT_LEVEL - 1);

   logic                        hold_valid;
   logic                        hold_last;
   logic                        zp_en_r;
   logic [3:0]                  zp_r;
   logic [CNT_W-1:0]            beat_cnt;
   logic [INPUT_DATA_WIDTH-1:0] hold_data;
   logic [INPUT_DATA_WIDTH-1:0] shifted_data;
   logic [BEAT_W-1:0]           beat_data;
   logic                        last_beat;
   logic                        fire_in;
   logic                        fire_out;

   assign last_beat = (beat_cnt == LAST_BEAT);
   assign valid_out = hold_valid;
   assign last_out  = hold_valid && hold_last && last_beat;
   assign fire_out  = hold_valid && ready_in;
   // Refill in the same cycle the final beat leaves, so consecutive words have no bubble.
   assign ready_out = !hold_valid || (fire_out && last_beat);
   assign fire_in   = valid_in && ready_out;

   assign shifted_data = hold_data >> (32'(beat_cnt) * BEAT_W);
   assign beat_data    = shifted_data[BEAT_W-1:0];

   always_comb begin
      data_out = '0;
      for (int i = 0; i < LANES; i++) begin
         if (zp_en_r)
            data_out[8*i +: 8] = {4'b0, beat_data[4*i +: 4]} - {4'b0, zp_r};
         else
            data_out[8*i +: 8] = {{4{beat_data[4*i+3]}}, beat_data[4*i +: 4]};
      end
   end

   // ap_start wins over both handshakes and discards whatever word is in flight.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         hold_valid <= 1'b0;
         hold_last  <= 1'b0;
         hold_data  <= '0;
         beat_cnt   <= '0;
         zp_en_r    <= 1'b0;
         zp_r       <= 4'd0;
      end else if (ap_start) begin
         hold_valid <= 1'b0;
         hold_last  <= 1'b0;
         hold_data  <= '0;
         beat_cnt   <= '0;
         zp_en_r    <= zp_en;
         zp_r       <= zp;
      end else if (fire_out) begin
         if (!last_beat) begin
            beat_cnt <= beat_cnt + 1'b1;
         end else if (fire_in) begin
            hold_data <= data_in;
            hold_last <= last_in;
            beat_cnt  <= '0;
         end else begin
            hold_valid <= 1'b0;
            beat_cnt   <= '0;
         end
      end else if (fire_in) begin
         hold_data  <= data_in;
         hold_last  <= last_in;
         hold_valid <= 1'b1;
         beat_cnt   <= '0;
      end
   end

endmodule
